// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg -- shared definitions for the round-robin grant arbiter.
//   arb_state_e : FSM state encoding (IDLE / GRANT)
//   idx_w()     : width of a requester index for n requesters
//   cnt_w()     : width of the burst counter, wide enough to hold max_burst
package rr_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // Clamp to 1 so a degenerate parameter still elaborates far enough to
   // reach the explicit parameter check in the top.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int max_burst);
      return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
   endfunction

endpackage

// File: rtl/rr_mask_pick.sv
// rr_mask_pick -- combinational wrap-around priority pick.
//   Returns the lowest set index of req_i that is >= ptr_i, wrapping from
//   N-1 back to 0. ptr_i is assumed to be < N (the owner keeps it modulo N).
// Ports:
//   req_i   [N-1:0]  request bits
//   ptr_i   [W-1:0]  search start index
//   found_o          at least one request bit set
//   idx_o   [W-1:0]  winning index (0 when found_o is low)
module rr_mask_pick #(
   parameter int N = 5,
   parameter int W = 3
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic         found_o,
   output logic [W-1:0] idx_o
);

   // Walk the offsets from farthest to nearest so the nearest set bit at or
   // after ptr_i is the last one written and therefore wins.
   always_comb begin
      int j;
      j       = 0;
      found_o = 1'b0;
      idx_o   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(ptr_i) + k;
         if (j >= N) j = j - N;   // modulo N, never into the unused 2**W range
         if (req_i[j[W-1:0]]) begin
            found_o = 1'b1;
            idx_o   = W'(j);
         end
      end
   end

endmodule

// File: rtl/rr_arb_grant.sv
// rr_arb_grant -- round-robin arbiter with registered, non-retractable grant.
//   A winner is registered from req_i (qualified by req_val_i) and held until
//   the consumer acks. At the end of a tenure the next winner is chosen in the
//   same cycle from the rotated pointer, so back-to-back grants have no bubble.
//   Build option: define RR_ARB_BURST_EN to let one requester keep the grant
//   for up to MAX_BURST acks while it keeps requesting. Without it every
//   tenure ends on its first ack and gnt_last_o equals gnt_val_o.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_i [REQ_NUM-1:0]     requests
//   req_val_i               qualifies req_i for new winner selection
//   gnt_ack_i               consumer accepts the current grant
//   gnt_val_o               grant valid
//   gnt_num_o [REQ_W-1:0]   granted index
//   gnt_onehot_o            one-hot of gnt_num_o, zero when no grant
//   gnt_last_o              next ack ends the tenure on burst count
module rr_arb_grant
   import rr_arb_pkg::*;
#(
   parameter int  REQ_NUM   = 5,
   parameter int  MAX_BURST = 3,
   localparam int REQ_W     = idx_w(REQ_NUM)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [REQ_NUM-1:0] req_i,
   input  logic               req_val_i,
   input  logic               gnt_ack_i,
   output logic               gnt_val_o,
   output logic [REQ_W-1:0]   gnt_num_o,
   output logic [REQ_NUM-1:0] gnt_onehot_o,
   output logic               gnt_last_o
);

   localparam int              CNT_W    = cnt_w(MAX_BURST);
   localparam logic [REQ_W-1:0] LAST_IDX = REQ_W'(REQ_NUM - 1);

   if (REQ_NUM < 2) begin : g_bad_req_num
      $error("rr_arb_grant: REQ_NUM must be >= 2");
   end
   if (MAX_BURST < 1) begin : g_bad_max_burst
      $error("rr_arb_grant: MAX_BURST must be >= 1");
   end

   arb_state_e       state_q, state_d;
   logic [REQ_W-1:0] ptr_q, ptr_d;
   logic [REQ_W-1:0] gnt_num_q, gnt_num_d;
   logic [CNT_W-1:0] burst_q, burst_d;

   logic             gnt_val;
   logic             keep;
   logic             last;
   logic [REQ_W-1:0] ptr_next;
   logic             idle_found, end_found;
   logic [REQ_W-1:0] idle_idx, end_idx;

   assign gnt_val  = (state_q == ST_GRANT);
   // Pointer after the current grant ends: one past the winner, modulo REQ_NUM.
   assign ptr_next = (gnt_num_q == LAST_IDX) ? '0 : gnt_num_q + REQ_W'(1);

   // Pick from the stored pointer while idle.
   rr_mask_pick #(.N(REQ_NUM), .W(REQ_W)) u_pick_idle (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .found_o (idle_found),
      .idx_o   (idle_idx)
   );

   // Pick from the rotated pointer so a tenure can hand over without a gap.
   rr_mask_pick #(.N(REQ_NUM), .W(REQ_W)) u_pick_end (
      .req_i   (req_i),
      .ptr_i   (ptr_next),
      .found_o (end_found),
      .idx_o   (end_idx)
   );

`ifdef RR_ARB_BURST_EN
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
   // Stay on the same requester only while it still asks and has beats left.
   assign keep = req_i[gnt_num_q] && (burst_q < BURST_LAST);
   assign last = gnt_val && (burst_q == BURST_LAST);
`else
   assign keep = 1'b0;
   assign last = gnt_val;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_num_d = gnt_num_q;
      burst_d   = burst_q;
      case (state_q)
         ST_IDLE: begin
            if (req_val_i && idle_found) begin
               state_d   = ST_GRANT;
               gnt_num_d = idle_idx;
            end
         end
         ST_GRANT: begin
            if (gnt_ack_i) begin
               if (keep) begin
                  burst_d = burst_q + CNT_W'(1);
               end else begin
                  ptr_d   = ptr_next;
                  burst_d = '0;
                  if (req_val_i && end_found) begin
                     gnt_num_d = end_idx;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         gnt_num_q <= '0;
         burst_q   <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_num_q <= gnt_num_d;
         burst_q   <= burst_d;
      end
   end

   always_comb begin
      gnt_onehot_o = '0;
      if (gnt_val) gnt_onehot_o[gnt_num_q] = 1'b1;
   end

   assign gnt_val_o  = gnt_val;
   assign gnt_num_o  = gnt_num_q;
   assign gnt_last_o = last;

endmodule

// File: tb/tb_rr_arb_grant.sv
// tb_rr_arb_grant -- directed bench for rr_arb_grant (REQ_NUM=5, MAX_BURST=3).
// Expected grant sequences are queued before each scenario and popped as the
// DUT presents grants. Honors RR_ARB_BURST_EN the same way the design does.
module tb_rr_arb_grant;

`ifdef RR_ARB_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [4:0] req_i;
   logic       req_val_i;
   logic       gnt_ack_i;
   logic       gnt_val_o;
   logic [2:0] gnt_num_o;
   logic [4:0] gnt_onehot_o;
   logic       gnt_last_o;

   typedef struct {
      int num;
      bit last;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   rr_arb_grant #(.REQ_NUM(5), .MAX_BURST(3)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_i        (req_i),
      .req_val_i    (req_val_i),
      .gnt_ack_i    (gnt_ack_i),
      .gnt_val_o    (gnt_val_o),
      .gnt_num_o    (gnt_num_o),
      .gnt_onehot_o (gnt_onehot_o),
      .gnt_last_o   (gnt_last_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".val"},    32'(gnt_val_o),    32'd0);
      chk({tag, ".num"},    32'(gnt_num_o),    32'd0);
      chk({tag, ".onehot"}, 32'(gnt_onehot_o), 32'd0);
      chk({tag, ".last"},   32'(gnt_last_o),   32'd0);
   endtask

   task automatic do_reset();
      rst_i     = 1'b1;
      req_i     = 5'b00000;
      req_val_i = 1'b0;
      gnt_ack_i = 1'b0;
      #1;
      chk_idle_outputs("rst");
      step();
      step();
      rst_i = 1'b0;
   endtask

   // Last beat of a tenure: every grant without bursts, every third with.
   task automatic push_seq(input int s[]);
      foreach (s[i]) begin
         exp_t e;
         e.num  = s[i];
         e.last = BURST ? ((i % 3) == 2) : 1'b1;
         exp_q.push_back(e);
      end
   endtask

   // Ack is held high by the caller, so a grant must appear every cycle.
   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 40) begin
         step();
         guard++;
         chk({tag, ".val"}, 32'(gnt_val_o), 32'd1);
         if (gnt_val_o === 1'b1) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({tag, ".num"},    32'(gnt_num_o),    32'(e.num));
            chk({tag, ".onehot"}, 32'(gnt_onehot_o), 32'd1 << e.num);
            chk({tag, ".last"},   32'(gnt_last_o),   32'(e.last));
         end
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $error("FAIL %s.timeout: observed %0d pending expected 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      int rot[];
      int wrp[];
      int bst[];
`ifdef RR_ARB_BURST_EN
      rot = '{1, 1, 1, 2, 2, 2, 4, 4, 4, 1};
      wrp = '{4, 4, 4, 0, 0, 0, 4};
      bst = '{0, 0, 0, 1, 1, 1, 0};
`else
      rot = '{1, 2, 4, 1, 2};
      wrp = '{4, 0, 4, 0};
      bst = '{0, 1, 0, 1, 0, 1, 0};
`endif

      // Reset with every requester active: outputs held low before any edge.
      rst_i     = 1'b1;
      req_i     = 5'b11111;
      req_val_i = 1'b1;
      gnt_ack_i = 1'b0;
      #2;
      chk_idle_outputs("rst_async");
      step();
      step();
      chk_idle_outputs("rst_clocked");
      rst_i = 1'b0;
      step();
      chk("rst_rel.val",    32'(gnt_val_o),    32'd1);
      chk("rst_rel.num",    32'(gnt_num_o),    32'd0);
      chk("rst_rel.onehot", 32'(gnt_onehot_o), 32'b00001);
      chk("rst_rel.last",   32'(gnt_last_o),   32'(!BURST));
      // Requests vanish as the tenure ends.
      req_i     = 5'b00000;
      req_val_i = 1'b0;
      gnt_ack_i = 1'b1;
      step();
      chk("rst_end.val", 32'(gnt_val_o), 32'd0);

      // Rotation with ack every cycle; the first ack arrives while no grant.
      do_reset();
      req_i     = 5'b10110;
      req_val_i = 1'b1;
      gnt_ack_i = 1'b1;
      push_seq(rot);
      drain("rot");
      req_i     = 5'b00000;
      req_val_i = 1'b0;
      step();
      chk("rot_end.val", 32'(gnt_val_o), 32'd0);

      // Wrap at index 4: ptr is moved to 4 by granting and retiring index 3.
      do_reset();
      req_i     = 5'b01000;
      req_val_i = 1'b1;
      step();
      chk("wrap_pre.num", 32'(gnt_num_o), 32'd3);
      req_i     = 5'b00000;
      req_val_i = 1'b0;
      gnt_ack_i = 1'b1;
      step();
      chk("wrap_pre.val", 32'(gnt_val_o), 32'd0);
      req_i     = 5'b10001;
      req_val_i = 1'b1;
      push_seq(wrp);
      drain("wrap");
      req_i     = 5'b00000;
      req_val_i = 1'b0;
      step();
      chk("wrap_end.val", 32'(gnt_val_o), 32'd0);

      // Two requesters held, ack every cycle.
      do_reset();
      req_i     = 5'b00011;
      req_val_i = 1'b1;
      gnt_ack_i = 1'b1;
      push_seq(bst);
      drain("burst");
      req_i     = 5'b00000;
      req_val_i = 1'b0;
      step();
      chk("burst_end.val", 32'(gnt_val_o), 32'd0);

      // Stalled consumer; the granted request drops in the second stall cycle.
      do_reset();
      req_i     = 5'b00100;
      req_val_i = 1'b1;
      step();
      chk("stall0.num", 32'(gnt_num_o), 32'd2);
      for (int c = 0; c < 4; c++) begin
         if (c == 1) req_i = 5'b00000;
         step();
         chk("stall.val",    32'(gnt_val_o),    32'd1);
         chk("stall.num",    32'(gnt_num_o),    32'd2);
         chk("stall.onehot", 32'(gnt_onehot_o), 32'b00100);
      end
      gnt_ack_i = 1'b1;
      step();
      chk("stall_end.val",    32'(gnt_val_o),    32'd0);
      chk("stall_end.onehot", 32'(gnt_onehot_o), 32'd0);
      gnt_ack_i = 1'b0;

      // Reset in the middle of a tenure after ptr has moved to 1.
      do_reset();
      req_i     = 5'b00011;
      req_val_i = 1'b1;
      step();
      chk("mid0.num", 32'(gnt_num_o), 32'd0);
      req_i     = 5'b00010;
      gnt_ack_i = 1'b1;
      step();
      chk("mid1.num", 32'(gnt_num_o), 32'd1);
      gnt_ack_i = 1'b0;
      #3;
      rst_i = 1'b1;
      #1;
      chk_idle_outputs("mid_rst");
      step();
      rst_i = 1'b0;
      req_i = 5'b00011;
      step();
      chk("mid_ptr0.val", 32'(gnt_val_o), 32'd1);
      chk("mid_ptr0.num", 32'(gnt_num_o), 32'd0);
      // Tenure ends with requests no longer qualified.
      req_i     = 5'b00010;
      req_val_i = 1'b0;
      gnt_ack_i = 1'b1;
      step();
      chk("noval.val", 32'(gnt_val_o), 32'd0);
      step();
      chk("noval_hold.val",    32'(gnt_val_o),    32'd0);
      chk("noval_hold.onehot", 32'(gnt_onehot_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_arb_grant.md
RR_ARB_GRANT -- requirements
Module: rr_arb_grant

Interface
REQ-001 SHALL have parameter REQ_NUM, default 5: number of requesters, any value >= 2, not limited to powers of two.
REQ-002 SHALL have parameter MAX_BURST, default 3: maximum acks per grant tenure, >= 1.
REQ-003 SHALL have port clk_i, input, 1: the single clock.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req_i, input, REQ_NUM: per-requester request bits.
REQ-006 SHALL have port req_val_i, input, 1: qualifies req_i; new winners are chosen only while high.
REQ-007 SHALL have port gnt_ack_i, input, 1: consumer accepts the current grant.
REQ-008 SHALL have port gnt_val_o, output, 1: grant valid.
REQ-009 SHALL have port gnt_num_o, output, REQ_W = $clog2(REQ_NUM): granted requester index.
REQ-010 SHALL have port gnt_onehot_o, output, REQ_NUM: one-hot copy of gnt_num_o, all zero when gnt_val_o is low.
REQ-011 SHALL have port gnt_last_o, output, 1: the next ack ends the tenure because burst_cnt == MAX_BURST-1.

Function
REQ-012 SHALL implement FSM states IDLE and GRANT.
REQ-013 SHALL pick a winner from req_i: the lowest set index >= ptr, wrapping from REQ_NUM-1 to 0; ptr wraps modulo REQ_NUM, never to 2**REQ_W.
REQ-014 SHALL move from IDLE to GRANT when req_val_i is high and req_i is non-zero, registering the winner; gnt_val_o rises exactly 1 cycle after the request is sampled.
REQ-015 SHALL keep gnt_num_o and gnt_onehot_o stable while in GRANT without gnt_ack_i, even if the granted request drops; a grant is never retracted.
REQ-016 SHALL increment burst_cnt on each cycle where gnt_val_o and gnt_ack_i are both high.
REQ-017 SHALL keep the same grant after an ack while the burst feature is compiled in, req_i[gnt_num_o] is still high and burst_cnt+1 < MAX_BURST.
REQ-018 SHALL otherwise end the tenure: ptr <= gnt_num_o+1 (wrapped), burst_cnt <= 0.
REQ-019 SHALL, at the end of a tenure, pick the next winner in the same cycle using the new ptr and current req_i, qualified by req_val_i, so there is no idle bubble; with no qualified request, gnt_val_o falls the next cycle and the FSM returns to IDLE.
REQ-020 SHALL leave ptr unchanged when no grant ends.
REQ-021 SHALL ignore gnt_ack_i while gnt_val_o is low.
REQ-022 SHALL ignore req_i bits at indices >= REQ_NUM; none exist at the ports.
REQ-023 SHALL give burst_cnt a width of $clog2(MAX_BURST+1).
REQ-024 SHALL stop elaboration with an error if REQ_NUM < 2 or MAX_BURST < 1.

Reset
REQ-025 SHALL, while rst_i is high and independent of the clock, hold state IDLE, ptr 0, burst_cnt 0, gnt_val_o 0, gnt_num_o 0, gnt_onehot_o 0 and gnt_last_o 0.
REQ-026 SHALL abort any grant when rst_i is asserted mid-tenure, with no ack completion implied.

Configuration
REQ-027 SHALL provide macro RR_ARB_BURST_EN: when defined, bursts behave per REQ-017.
REQ-028 SHALL, when RR_ARB_BURST_EN is undefined, end every tenure on its first ack, tie gnt_last_o to gnt_val_o and leave MAX_BURST unused.

Structure
REQ-029 SHALL place the FSM state enum and the width helper constants in the shared package rr_arb_pkg.
REQ-030 SHALL put the wrap-around masked pick (req, ptr -> found, index) in the combinational sub-module rr_mask_pick, instantiated twice: once for the IDLE pick and once for the end-of-tenure pick.
REQ-031 SHALL keep all state in rr_arb_grant.

Verification (REQ_NUM=5, MAX_BURST=3)
REQ-032 SHALL cover reset: rst_i pulsed with req_i=5'b11111 -> all outputs 0 during reset; gnt_val_o=1 with gnt_num_o=0 one cycle after release.
REQ-033 SHALL cover rotation: burst off, req_i=5'b10110 held, ack every cycle -> gnt_num_o 1,2,4,1,2 back-to-back with gnt_val_o continuously 1.
REQ-034 SHALL cover non-power-of-two wrap: ptr=4, req_i=5'b10001 -> grants 4 then 0, never index 5-7.
REQ-035 SHALL cover burst: burst on, req_i=5'b00011 held, ack every cycle -> 0,0,0,1,1,1,0; gnt_last_o high on each third ack.
REQ-036 SHALL cover a stalled consumer: grant to 2, ack withheld 4 cycles, req_i[2] dropped in cycle 2 -> gnt_num_o stays 2 and gnt_val_o stays 1 until the ack.
REQ-037 SHALL cover mid-tenure reset and requests going away: rst_i asserted in GRANT -> gnt_val_o 0 immediately and ptr 0; req_val_i=0 at tenure end -> IDLE, gnt_val_o 0.
